// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds bytes from NUM_REQ packet sources into one UART
// transmitter, locking the transmitter to one source per packet, with a byte-done watchdog.
module uart_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_en_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_busy_i,
    input  logic                       tx_send_byte_done_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       grant_valid_o,
    output logic                       timeout_err_o,
    output logic [15:0]                pkt_cnt_o
);
    localparam int GW   = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]   LAST_IDX = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
    state_t state, state_nxt;

    logic [GW-1:0]   rr_ptr, pick, idx, grant_inc;
    logic            pick_hit, own_valid, own_last, last_flag;
    logic            xfer, done_last, abort;
    logic [7:0]      own_data;
    logic [WD_W-1:0] wd_cnt;

    // Scan downwards so the requester closest to rr_ptr is the last to be written.
    always_comb begin
        pick     = '0;
        pick_hit = 1'b0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid_i[idx]) begin
                pick     = idx;
                pick_hit = 1'b1;
            end
        end
    end

    assign own_valid = req_valid_i[grant_o];
    assign own_last  = req_last_i[grant_o];
    assign own_data  = req_data_i[{grant_o, 3'b000} +: 8];
    assign grant_inc = (grant_o == LAST_IDX) ? '0 : grant_o + 1'b1;

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        xfer        = 1'b0;
        done_last   = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_hit) state_nxt = SEND;
            end
            SEND: begin
                if (own_valid && !tx_busy_i) begin
                    xfer                 = 1'b1;
                    req_ready_o[grant_o] = 1'b1;
                    state_nxt            = WAIT;
                end
            end
            WAIT: begin
                // A done arriving on the final watchdog cycle still completes the byte.
                if (tx_send_byte_done_i) begin
                    done_last = last_flag;
                    state_nxt = last_flag ? IDLE : SEND;
                end else if (wd_cnt == WD_MAX) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_en_o       <= 1'b0;
            tx_data_o     <= '0;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            timeout_err_o <= 1'b0;
            pkt_cnt_o     <= '0;
            rr_ptr        <= '0;
            wd_cnt        <= '0;
            last_flag     <= 1'b0;
        end else begin
            tx_en_o       <= xfer;
            timeout_err_o <= abort;
            if (state == IDLE && pick_hit) begin
                grant_o       <= pick;
                grant_valid_o <= 1'b1;
            end
            if (xfer) begin
                tx_data_o <= own_data;
                last_flag <= own_last;
                wd_cnt    <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done_last) pkt_cnt_o <= pkt_cnt_o + 1'b1;
            if (done_last || abort) begin
                rr_ptr        <= grant_inc;
                grant_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one instance with the default watchdog, one with a
// 16-cycle watchdog, both driven by the same stimulus.
module tb_uart_tx_sched;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_last;
    logic [8*NR-1:0] req_data;
    logic            tx_busy, tx_done;
    logic [NR-1:0]   ready_a, ready_b;
    logic            tx_en_a, tx_en_b, gv_a, gv_b, err_a, err_b;
    logic [7:0]      tx_data_a, tx_data_b;
    logic [1:0]      grant_a, grant_b;
    logic [15:0]     pkt_a, pkt_b;

    int   n_chk = 0;
    int   n_fail = 0;
    int   bad, hits, first;
    bit   ok;
    logic gv_at;
    logic [15:0] pkt_at;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(NR)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_last_i(req_last), .req_ready_o(ready_a), .tx_en_o(tx_en_a), .tx_data_o(tx_data_a),
        .tx_busy_i(tx_busy), .tx_send_byte_done_i(tx_done), .grant_o(grant_a),
        .grant_valid_o(gv_a), .timeout_err_o(err_a), .pkt_cnt_o(pkt_a)
    );

    uart_tx_sched #(.NUM_REQ(NR), .TIMEOUT_CYC(16)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_last_i(req_last), .req_ready_o(ready_b), .tx_en_o(tx_en_b), .tx_data_o(tx_data_b),
        .tx_busy_i(tx_busy), .tx_send_byte_done_i(tx_done), .grant_o(grant_b),
        .grant_valid_o(gv_b), .timeout_err_o(err_b), .pkt_cnt_o(pkt_b)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        done;
        logic [3:0]  ready;
        logic        tx_en;
        logic [7:0]  tx_data;
        logic [1:0]  grant;
        logic        gv;
        logic [15:0] pkt;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [63:0] out_a();
        return 64'({ready_a, tx_en_a, tx_data_a, grant_a, gv_a, err_a, pkt_a});
    endfunction

    function automatic logic [63:0] out_b();
        return 64'({ready_b, tx_en_b, tx_data_b, grant_b, gv_b, err_b, pkt_b});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns ok=1 at #1 into the first cycle where the requester is handed a byte slot.
    task automatic wait_ready(input bit use_b, input int k, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((use_b ? ready_b[k] : ready_a[k]) == 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One byte through dut_a; done arrives dly cycles after the launch cycle.
    task automatic send_a(input int k, input logic [7:0] b, input logic lst, input int dly,
                          input string tag);
        bit got;
        int extra;
        req_data[8*k +: 8] = b;
        req_last[k]        = lst;
        wait_ready(1'b0, k, got);
        chk({tag, "_hs"}, 64'(got), 64'd1);
        chk({tag, "_rdy"}, 64'(ready_a), 64'(4'b0001 << k));
        @(negedge clk); #1;
        chk({tag, "_launch"}, 64'({tx_en_a, tx_data_a, grant_a}), 64'({1'b1, b, 2'(k)}));
        extra = 0;
        repeat (dly - 1) begin
            @(negedge clk); #1;
            if (tx_en_a || ready_a != '0) extra++;
        end
        @(negedge clk); tx_done = 1'b1; #1;
        @(negedge clk); tx_done = 1'b0;
        chk({tag, "_quiet"}, 64'(extra), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        //              valid done  ready tx_en data  grant gv pkt
        tbl[0]  = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
        tbl[1]  = '{4'hF, 1'b0, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0};
        tbl[2]  = '{4'hF, 1'b1, 4'h0, 1'b1, 8'h10, 2'd0, 1'b1, 16'd0};
        tbl[3]  = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h10, 2'd0, 1'b0, 16'd1};
        tbl[4]  = '{4'hF, 1'b0, 4'h2, 1'b0, 8'h10, 2'd1, 1'b1, 16'd1};
        tbl[5]  = '{4'hF, 1'b1, 4'h0, 1'b1, 8'h11, 2'd1, 1'b1, 16'd1};
        tbl[6]  = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1, 1'b0, 16'd2};
        tbl[7]  = '{4'hF, 1'b0, 4'h4, 1'b0, 8'h11, 2'd2, 1'b1, 16'd2};
        tbl[8]  = '{4'hF, 1'b1, 4'h0, 1'b1, 8'h12, 2'd2, 1'b1, 16'd2};
        tbl[9]  = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h12, 2'd2, 1'b0, 16'd3};
        tbl[10] = '{4'hF, 1'b0, 4'h8, 1'b0, 8'h12, 2'd3, 1'b1, 16'd3};
        tbl[11] = '{4'hF, 1'b1, 4'h0, 1'b1, 8'h13, 2'd3, 1'b1, 16'd3};
        tbl[12] = '{4'hF, 1'b0, 4'h0, 1'b0, 8'h13, 2'd3, 1'b0, 16'd4};
        tbl[13] = '{4'hF, 1'b0, 4'h1, 1'b0, 8'h13, 2'd0, 1'b1, 16'd4};

        // Reset state, then round-robin over four one-byte packets
        do_reset();
        #1;
        chk("reset_a", out_a(), 64'd0);
        chk("reset_b", out_b(), 64'd0);
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_last = 4'hF;
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid;
            tx_done   = tbl[i].done;
            #1;
            chk($sformatf("rr_row%0d", i), out_a(),
                64'({tbl[i].ready, tbl[i].tx_en, tbl[i].tx_data, tbl[i].grant, tbl[i].gv,
                     1'b0, tbl[i].pkt}));
            @(negedge clk);
        end
        tx_done = 1'b0;

        // Two-byte packet from requester 2, done 20 cycles after each launch
        do_reset();
        req_valid = 4'b0100;
        send_a(2, 8'h55, 1'b0, 20, "pkt_b0");
        #1;
        chk("pkt_mid", 64'({gv_a, grant_a, pkt_a}), 64'({1'b1, 2'd2, 16'd0}));
        send_a(2, 8'hAA, 1'b1, 20, "pkt_b1");
        req_valid = 4'hF;
        req_last  = 4'hF;
        #1;
        chk("pkt_done", 64'({pkt_a, gv_a, grant_a}), 64'({16'd1, 1'b0, 2'd2}));
        wait_ready(1'b0, 3, ok);
        chk("pkt_rr_next", 64'({ok, grant_a}), 64'({1'b1, 2'd3}));

        // Packet lock: requester 0 waits out requester 1's three-byte packet
        do_reset();
        req_valid = 4'b0010;
        send_a(1, 8'h31, 1'b0, 3, "lock_b0");
        req_valid[0] = 1'b1;
        send_a(1, 8'h32, 1'b0, 3, "lock_b1");
        req_valid[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ready_a != '0 || tx_en_a || grant_a != 2'd1 || !gv_a) bad++;
            @(negedge clk);
        end
        chk("lock_hold", 64'(bad), 64'd0);
        req_valid[1] = 1'b1;
        send_a(1, 8'h33, 1'b1, 3, "lock_b2");
        req_valid[1] = 1'b0;
        #1;
        chk("lock_pkt", 64'(pkt_a), 64'd1);
        wait_ready(1'b0, 0, ok);
        chk("lock_wrap", 64'({ok, grant_a}), 64'({1'b1, 2'd0}));

        // Busy gate, with a stray done while in SEND
        do_reset();
        tx_busy   = 1'b1;
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data[7:0] = 8'h77;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (ready_a != '0 || tx_en_a) bad++;
            @(negedge clk);
            tx_done = (i == 3);
        end
        tx_done = 1'b0;
        #1;
        chk("busy_hold", 64'(bad), 64'd0);
        chk("busy_grant", 64'({gv_a, grant_a, pkt_a}), 64'({1'b1, 2'd0, 16'd0}));
        tx_busy = 1'b0;
        #1;
        chk("busy_release_rdy", 64'(ready_a), 64'(4'b0001));
        @(negedge clk); #1;
        chk("busy_launch", 64'({tx_en_a, tx_data_a}), 64'({1'b1, 8'h77}));

        // Watchdog abort on the 16-cycle instance
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data[7:0] = 8'h99;
        wait_ready(1'b1, 0, ok);
        chk("wd_hs", 64'(ok), 64'd1);
        @(negedge clk); #1;
        chk("wd_launch", 64'(tx_en_b), 64'd1);
        first  = 0;
        hits   = 0;
        gv_at  = 1'b1;
        pkt_at = 16'hFFFF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            if (err_b) begin
                hits++;
                if (first == 0) begin
                    first  = i;
                    gv_at  = gv_b;
                    pkt_at = pkt_b;
                end
            end
        end
        chk("wd_cycle", 64'(first), 64'd16);
        chk("wd_pulses", 64'(hits), 64'd1);
        chk("wd_gv", 64'(gv_at), 64'd0);
        chk("wd_pkt", 64'(pkt_at), 64'd0);

        // Done on the last watchdog cycle wins over the abort
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        wait_ready(1'b1, 0, ok);
        @(negedge clk); #1;
        chk("wd15_launch", 64'(tx_en_b), 64'd1);
        hits = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            tx_done = (i == 15);
            if (i == 16) req_valid = '0;
            #1;
            if (err_b) hits++;
        end
        tx_done = 1'b0;
        chk("wd15_err", 64'(hits), 64'd0);
        chk("wd15_pkt", 64'(pkt_b), 64'd1);

        // Packet counter wrap, then asynchronous reset in the middle of WAIT
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'hF;
        send_a(1, 8'h41, 1'b1, 2, "pre");
        force dut_a.pkt_cnt_o = 16'hFFFF;
        #1;
        release dut_a.pkt_cnt_o;
        #1;
        chk("wrap_preset", 64'(pkt_a), 64'hFFFF);
        req_valid = 4'b1000;
        send_a(3, 8'h43, 1'b1, 2, "wrap");
        #1;
        chk("wrap_cnt", 64'(pkt_a), 64'd0);
        req_valid = 4'b0010;
        send_a(1, 8'h44, 1'b1, 2, "pre2");
        req_valid = 4'b1000;
        wait_ready(1'b0, 3, ok);
        @(negedge clk); #1;
        chk("rw_launch", 64'({tx_en_a, grant_a, pkt_a}), 64'({1'b1, 2'd3, 16'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_a", out_a(), 64'd0);
        chk("rst_async_b", out_b(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        wait_ready(1'b0, 1, ok);
        chk("rst_rr0", 64'({ok, grant_a}), 64'({1'b1, 2'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter, legal 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 65536: maximum cycles from byte launch to byte-done before abort, legal 16..2^20.
REQ-003 clk_i  input  1  system clock, all logic on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid_i  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data_i  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 req_last_i  input  NUM_REQ  byte is last of requester's packet.
REQ-008 req_ready_o  output  NUM_REQ  byte accepted this cycle (valid & ready = transfer).
REQ-009 tx_en_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data_o  output  8  byte to the UART transmitter, held stable from tx_en_o until next launch.
REQ-011 tx_busy_i  input  1  UART transmitter busy.
REQ-012 tx_send_byte_done_i  input  1  UART transmitter one-cycle byte-complete pulse.
REQ-013 grant_o  output  clog2(NUM_REQ)  index of current owner.
REQ-014 grant_valid_o  output  1  an owner holds the transmitter.
REQ-015 timeout_err_o  output  1  one-cycle pulse on watchdog abort.
REQ-016 pkt_cnt_o  output  16  count of packets completed with req_last_i, wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states IDLE, SEND, WAIT; encoding free.
REQ-018 IDLE: when any req_valid_i bit set, grant lowest-index set bit at or after rr_ptr, modulo NUM_REQ; latch grant_o, set grant_valid_o, go SEND next cycle.
REQ-019 SEND: when req_valid_i[grant_o]=1 and tx_busy_i=0, assert req_ready_o[grant_o] (combinational) that cycle, register tx_en_o=1 and tx_data_o=byte for next cycle, latch last flag, go WAIT.
REQ-020 SEND with owner valid low or tx_busy_i high: hold state, hold grant (packet lock), tx_en_o=0.
REQ-021 req_ready_o bits other than grant_o SHALL be 0 at all times; req_ready_o all 0 outside SEND.
REQ-022 tx_en_o SHALL be high for exactly one cycle per accepted byte; one accepted byte yields one launch.
REQ-023 WAIT: on tx_send_byte_done_i: if last flag set, increment pkt_cnt_o, set rr_ptr=grant_o+1 modulo NUM_REQ, clear grant_valid_o, go IDLE; else go SEND.
REQ-024 WAIT watchdog: counter clears on entry, increments each cycle in WAIT; at TIMEOUT_CYC-1 without done, pulse timeout_err_o, clear grant_valid_o, set rr_ptr=grant_o+1, go IDLE, no pkt_cnt_o increment.
REQ-025 Done and timeout in same cycle: done wins, no timeout_err_o.
REQ-026 tx_send_byte_done_i outside WAIT: ignored.
REQ-027 New requests arriving while a packet is locked SHALL wait; no preemption.
REQ-028 Requester deasserting valid mid-packet keeps its lock until its last byte completes or a watchdog abort.
REQ-029 Minimum byte-to-byte spacing: launch, done, SEND, launch; no byte launched while tx_busy_i=1.

Reset
REQ-030 rst_n_i low SHALL immediately force: state IDLE, tx_en_o=0, tx_data_o=0x00, req_ready_o=0, grant_o=0, grant_valid_o=0, timeout_err_o=0, pkt_cnt_o=0, rr_ptr=0, watchdog=0.
REQ-031 Reset mid-packet SHALL discard lock and last flag; first grant after release follows REQ-018 from rr_ptr=0.

Verification
REQ-032 Single packet: req 2 sends 0x55,0xAA(last), done 20 cycles after each launch -> two tx_en_o pulses with data 0x55 then 0xAA, grant_o=2 throughout, pkt_cnt_o 0->1, rr_ptr=3.
REQ-033 Round-robin: all four valid, 1-byte packets, repeated -> grant sequence 0,1,2,3,0; no grant twice before others served.
REQ-034 Lock: req 1 mid 3-byte packet, req 0 asserts valid -> req 0 gets req_ready_o=0 until req 1 last byte done, then grant_o=2 if 2 valid else wraps to 0.
REQ-035 Watchdog: TIMEOUT_CYC=16, launch with no done -> timeout_err_o one pulse 16 cycles after WAIT entry, grant_valid_o=0, pkt_cnt_o unchanged; done on cycle 15 -> no error.
REQ-036 Busy gate: tx_busy_i=1 while owner valid in SEND -> no tx_en_o, no req_ready_o until busy drops, then launch next cycle.
REQ-037 Reset mid-WAIT and pkt_cnt_o preset near 0xFFFF: reset clears all outputs to REQ-030 values; separately 0xFFFF + 1 packet -> 0x0000.
